rename_dispatch_queue: RTL and testbench

//  - Decoupling FIFO between decode and the renaming stage; holds decoded instrs until rename accepts them.
//  - Drives rename's l_dst / l_dst_valid / inst_en inputs and honours its stall.
//  - Flushes all held instrs on recovery (rec_en); blocks issue to rename while rec_busy.

---
 rtl/rename_dispatch_queue.sv | 88 ++++++++
 tb/tb_rename_dispatch_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rename_dispatch_queue.sv
// rtl/rename_dispatch_queue.sv - decode-to-rename dispatch FIFO with recovery flush
// Define RDQ_BYPASS_EN to let a push into an empty queue issue to rename in the same cycle.
module rename_dispatch_queue #(
  parameter int L_REGISTERS = 32,
  parameter int DEPTH       = 4,
  parameter int PAYLOAD_W   = 32,
  localparam int LW = $clog2(L_REGISTERS),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LW-1:0]        in_l_dst,
  input  logic                 in_l_dst_vld,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 inst_en,
  output logic [LW-1:0]        l_dst,
  output logic                 l_dst_valid,
  output logic [PAYLOAD_W-1:0] payload,
  input  logic                 stall,
  input  logic                 rec_en,
  input  logic                 rec_busy,
  output logic [CW-1:0]        count
);

  localparam int EW = LW + 1 + PAYLOAD_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          hold;
  logic          push;
  logic          bypass;
  logic          wr_en;
  logic          rd_en;
  logic [EW-1:0] head;

  assign empty    = (count == '0);
  assign hold     = rec_busy | rec_en;
  assign in_ready = (count < FULL) & ~hold;
  assign push     = in_valid & in_ready;

`ifdef RDQ_BYPASS_EN
  assign bypass = empty & push;
`else
  assign bypass = 1'b0;
`endif

  assign inst_en = (~empty & ~hold) | bypass;

  // A bypassed instr that rename takes immediately never occupies an entry.
  assign wr_en = push & ~(bypass & ~stall);
  assign rd_en = inst_en & ~stall & ~bypass;

  always_comb begin
    head = '0;
    if (bypass)
      head = {in_l_dst, in_l_dst_vld, in_payload};
    else if (!empty)
      head = mem[rd_ptr];
  end

  assign l_dst       = head[EW-1 -: LW];
  assign l_dst_valid = head[PAYLOAD_W];
  assign payload     = head[PAYLOAD_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[wr_ptr] <= {in_l_dst, in_l_dst_vld, in_payload};
  end

  always_ff @(posedge clk) begin
    if (rst || rec_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: tb/tb_rename_dispatch_queue.sv
// tb/tb_rename_dispatch_queue.sv - directed bench for rename_dispatch_queue
module tb_rename_dispatch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_l_dst;
  logic        in_l_dst_vld;
  logic [31:0] in_payload;
  logic        inst_en;
  logic [4:0]  l_dst;
  logic        l_dst_valid;
  logic [31:0] payload;
  logic        stall;
  logic        rec_en;
  logic        rec_busy;
  logic [2:0]  count;

  int pass_cnt = 0;
  int total    = 0;

  rename_dispatch_queue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_l_dst(in_l_dst), .in_l_dst_vld(in_l_dst_vld), .in_payload(in_payload),
    .inst_en(inst_en), .l_dst(l_dst), .l_dst_valid(l_dst_valid), .payload(payload),
    .stall(stall), .rec_en(rec_en), .rec_busy(rec_busy), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] d);
    in_valid     = v;
    in_l_dst     = d;
    in_l_dst_vld = 1'b1;
    in_payload   = 32'hA000_0000 | 32'(d);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_l_dst = '0; in_l_dst_vld = 1'b0; in_payload = '0;
    stall = 1'b1; rec_en = 1'b0; rec_busy = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;
    total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
    total++; if (inst_en !== 1'b0) $display("FAIL reset_inst_en got %0b exp 0", inst_en); else pass_cnt++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready); else pass_cnt++;
    total++; if (l_dst !== 5'd0) $display("FAIL reset_l_dst_masked got %0d exp 0", l_dst); else pass_cnt++;
  endtask

  task automatic test_single_push();
    drive(1'b1, 5'd5);
    tick();
    in_valid = 1'b0; #1;
    total++; if (inst_en !== 1'b1) $display("FAIL single_inst_en got %0b exp 1", inst_en); else pass_cnt++;
    total++; if (l_dst !== 5'd5) $display("FAIL single_l_dst got %0d exp 5", l_dst); else pass_cnt++;
    total++; if (l_dst_valid !== 1'b1) $display("FAIL single_l_dst_valid got %0b exp 1", l_dst_valid); else pass_cnt++;
    total++; if (payload !== 32'hA000_0005) $display("FAIL single_payload got %h exp a0000005", payload); else pass_cnt++;
    total++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else pass_cnt++;
    stall = 1'b0;
    tick();
    stall = 1'b1; #1;
    total++; if (count !== 3'd0 || inst_en !== 1'b0)
      $display("FAIL single_drain got count=%0d inst_en=%0b exp 0/0", count, inst_en); else pass_cnt++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i));
      tick();
    end
    drive(1'b1, 5'd9); #1;
    total++; if (count !== 3'd4) $display("FAIL full_count got %0d exp 4", count); else pass_cnt++;
    total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %0b exp 0", in_ready); else pass_cnt++;
    tick();
    in_valid = 1'b0; #1;
    total++; if (count !== 3'd4) $display("FAIL full_fifth_ignored got %0d exp 4", count); else pass_cnt++;
    stall = 1'b0; #1;
    for (int i = 1; i <= 4; i++) begin
      total++; if (l_dst !== 5'(i)) $display("FAIL drain_l_dst[%0d] got %0d exp %0d", i, l_dst, i); else pass_cnt++;
      tick();
      total++; if (count !== 3'(4 - i)) $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 4 - i); else pass_cnt++;
    end
    total++; if (inst_en !== 1'b0) $display("FAIL drain_inst_en got %0b exp 0", inst_en); else pass_cnt++;
    stall = 1'b1;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd10); tick();
    drive(1'b1, 5'd11); tick();
    stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 5'(12 + k)); #1;
      total++; if (l_dst !== 5'(10 + k) || count !== 3'd2)
        $display("FAIL b2b[%0d] got l_dst=%0d count=%0d exp %0d/2", k, l_dst, count, 10 + k); else pass_cnt++;
      tick();
    end
    in_valid = 1'b0; stall = 1'b1; #1;
    total++; if (count !== 3'd2 || l_dst !== 5'd20)
      $display("FAIL b2b_end got count=%0d l_dst=%0d exp 2/20", count, l_dst); else pass_cnt++;
    stall = 1'b0; tick(); #1;
    total++; if (l_dst !== 5'd21) $display("FAIL b2b_tail got %0d exp 21", l_dst); else pass_cnt++;
    tick(); stall = 1'b1; #1;
    total++; if (count !== 3'd0) $display("FAIL b2b_drain got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(30 + i)); tick();
    end
    drive(1'b1, 5'd33); rec_en = 1'b1; #1;
    total++; if (in_ready !== 1'b0 || inst_en !== 1'b0)
      $display("FAIL flush_gate got in_ready=%0b inst_en=%0b exp 0/0", in_ready, inst_en); else pass_cnt++;
    tick();
    rec_en = 1'b0; in_valid = 1'b0; #1;
    total++; if (count !== 3'd0 || inst_en !== 1'b0)
      $display("FAIL flush_state got count=%0d inst_en=%0b exp 0/0", count, inst_en); else pass_cnt++;
    rec_busy = 1'b1; drive(1'b1, 5'd34); stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0 || inst_en !== 1'b0)
        $display("FAIL rec_busy[%0d] got in_ready=%0b inst_en=%0b exp 0/0", i, in_ready, inst_en); else pass_cnt++;
      tick();
    end
    rec_busy = 1'b0; in_valid = 1'b0; stall = 1'b1; #1;
    total++; if (count !== 3'd0) $display("FAIL rec_busy_no_push got %0d exp 0", count); else pass_cnt++;
  endtask

  task automatic test_rec_busy_hold();
    drive(1'b1, 5'd40); tick();
    drive(1'b1, 5'd41); tick();
    in_valid = 1'b0; rec_busy = 1'b1; stall = 1'b0; #1;
    total++; if (inst_en !== 1'b0) $display("FAIL hold_inst_en got %0b exp 0", inst_en); else pass_cnt++;
    tick(); tick();
    total++; if (count !== 3'd2) $display("FAIL hold_count got %0d exp 2", count); else pass_cnt++;
    rec_busy = 1'b0; #1;
    total++; if (inst_en !== 1'b1 || l_dst !== 5'd40)
      $display("FAIL resume got inst_en=%0b l_dst=%0d exp 1/40", inst_en, l_dst); else pass_cnt++;
    tick();
    total++; if (count !== 3'd1 || l_dst !== 5'd41)
      $display("FAIL resume_pop got count=%0d l_dst=%0d exp 1/41", count, l_dst); else pass_cnt++;
    tick(); stall = 1'b1; #1;
    total++; if (count !== 3'd0) $display("FAIL resume_drain got %0d exp 0", count); else pass_cnt++;
  endtask

`ifdef RDQ_BYPASS_EN
  task automatic test_bypass();
    stall = 1'b0; drive(1'b1, 5'd7); #1;
    total++; if (inst_en !== 1'b1 || l_dst !== 5'd7)
      $display("FAIL bypass_same got inst_en=%0b l_dst=%0d exp 1/7", inst_en, l_dst); else pass_cnt++;
    tick();
    in_valid = 1'b0; #1;
    total++; if (count !== 3'd0 || inst_en !== 1'b0)
      $display("FAIL bypass_pop got count=%0d inst_en=%0b exp 0/0", count, inst_en); else pass_cnt++;
    stall = 1'b1; drive(1'b1, 5'd7); #1;
    total++; if (inst_en !== 1'b1 || l_dst !== 5'd7)
      $display("FAIL bypass_stall got inst_en=%0b l_dst=%0d exp 1/7", inst_en, l_dst); else pass_cnt++;
    tick();
    in_valid = 1'b0; #1;
    total++; if (count !== 3'd1 || l_dst !== 5'd7)
      $display("FAIL bypass_written got count=%0d l_dst=%0d exp 1/7", count, l_dst); else pass_cnt++;
    stall = 1'b0; tick(); stall = 1'b1; #1;
    total++; if (count !== 3'd0) $display("FAIL bypass_drain got %0d exp 0", count); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_rec_busy_hold();
`ifdef RDQ_BYPASS_EN
    test_bypass();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
